// File: rtl/mux_8_1_arbiter_pkg.sv
// Shared constants, state encoding and grant payload for the mux_8_1 round-robin arbiter.
package mux_8_1_arbiter_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             valid;
  } grant_t;

  function automatic logic [N_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
    onehot_sel = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_8_1.sv
// Eight-way data mux shared between requesters; sel comes from mux_8_1_arbiter.
module mux_8_1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d [8],
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] o0
);

  always_comb begin
    o0 = d[sel];
  end

endmodule

// File: rtl/rr_pick_8.sv
// Combinational round-robin picker: first set req bit scanning from last+1 upward, wrapping 7->0.
module rr_pick_8
  import mux_8_1_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   off;

  // Rotate so bit 0 of req_rot is requester last+1; the 3-bit add wraps naturally.
  assign start   = last + SEL_W'(1);
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[start +: N_REQ];
  assign any     = |req;

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off = SEL_W'(i);
      end
    end
  end

  assign idx = start + off;

endmodule

// File: rtl/mux_8_1_arbiter.sv
// Round-robin arbiter for one shared mux_8_1: registered one-hot grant, mux select and
// hold-timeout so no requester can keep the mux longer than MAX_HOLD cycles.
module mux_8_1_arbiter
  import mux_8_1_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_e       state_q, state_d;
  grant_t           grant_q, grant_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  rr_pick_8 u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      last_q    <= SEL_W'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  // Next-state: arbitrate only in IDLE; in GRANT a dropped request beats hold expiry.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;
    unique case (state_q)
      ST_IDLE: begin
        grant_d.gnt   = '0;
        grant_d.valid = 1'b0;
        if (pick_any) begin
          grant_d.gnt   = onehot_sel(pick_idx);
          grant_d.sel   = pick_idx;
          grant_d.valid = 1'b1;
          last_d        = pick_idx;
          cnt_d         = '0;
          state_d       = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[grant_q.sel]) begin
          grant_d.gnt   = '0;
          grant_d.valid = 1'b0;
          state_d       = ST_IDLE;
        end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          grant_d.gnt   = '0;
          grant_d.valid = 1'b0;
          timeout_d     = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sel       = grant_q.sel;
  assign gnt       = grant_q.gnt;
  assign gnt_valid = grant_q.valid;
  assign timeout   = timeout_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_valid_eq_or: assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));
  a_valid_sel:   assert property (@(posedge clk) disable iff (rst) gnt_valid |-> gnt[sel]);
  a_timeout_idle: assert property (@(posedge clk) disable iff (rst) timeout |-> !gnt_valid);

endmodule

// File: tb/tb_mux_8_1_arbiter.sv
// Randomized and directed bench for mux_8_1_arbiter driving a mux_8_1, against a
// transaction-level round-robin model (owner / cycles held / last winner).
module tb_mux_8_1_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;
  logic [7:0] d [8];
  logic [7:0] o0;

  int n_checks;
  int n_fail;

  // Reference model state
  int   m_owner;
  int   m_held;
  int   m_last;
  int   m_sel;
  logic m_timeout;

  mux_8_1_arbiter #(
    .MAX_HOLD (HOLD),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  mux_8_1 #(.WIDTH(8)) u_mux (
    .d   (d),
    .sel (sel),
    .o0  (o0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_held    = 0;
    m_last    = 7;
    m_sel     = 0;
    m_timeout = 1'b0;
  endtask

  // One clock edge of the arbitration rules, given the req seen before the edge.
  task automatic model_step(input logic [7:0] r);
    int cand;
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      if (r != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          cand = (m_last + k) % 8;
          if (m_owner < 0 && r[cand]) m_owner = cand;
        end
        m_held = 1;
        m_last = m_owner;
        m_sel  = m_owner;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (m_held == HOLD) begin
      m_owner   = -1;
      m_timeout = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic compare();
    logic [7:0] exp_gnt;
    exp_gnt = 8'h00;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("timeout", 32'(timeout), 32'(m_timeout));
    if (m_owner >= 0) chk("o0", 32'(o0), 32'(d[m_sel]));
  endtask

  task automatic step(input logic [7:0] r);
    req = r;
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
    @(posedge clk);
    model_step(r);
    #1;
    compare();
  endtask

  initial begin
    logic [7:0] r;
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst = 1'b1;
    req = 8'h00;
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_valid", 32'(gnt_valid), 32'h0);
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;

    // Single requester, voluntary release
    repeat (5) step(8'h01);
    repeat (2) step(8'h00);

    // Everyone requesting: rotation with timeouts
    repeat (45) step(8'hFF);
    repeat (2) step(8'h00);

    // Pointer wrap 7 -> 0
    repeat (2) step(8'h40);
    repeat (2) step(8'h00);
    step(8'h81);
    chk("wrap_first", 32'(sel), 32'd7);
    repeat (2) step(8'h81);
    step(8'h01);
    step(8'h01);
    chk("wrap_second", 32'(sel), 32'd0);
    repeat (2) step(8'h00);

    // Drop on the expiry cycle: release without timeout
    repeat (HOLD) step(8'h04);
    step(8'h00);
    chk("coinc_timeout", 32'(timeout), 32'h0);
    step(8'h00);

    // Sole requester re-granted after each timeout
    repeat (12) step(8'h10);
    repeat (2) step(8'h00);

    // Random traffic
    r = 8'h00;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 8; b++) begin
        if (r[b]) begin
          if ($urandom_range(0, 5) == 0) r[b] = 1'b0;
        end else if ($urandom_range(0, 4) == 0) begin
          r[b] = 1'b1;
        end
      end
      step(r);
    end

    // Async reset in the middle of a grant
    repeat (2) step(8'h00);
    repeat (2) step(8'h08);
    #2;
    rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_valid", 32'(gnt_valid), 32'h0);
    chk("async_sel", 32'(sel), 32'h0);
    chk("async_timeout", 32'(timeout), 32'h0);
    model_reset();
    req = 8'h0C;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(8'h0C);
    chk("post_reset_winner", 32'(sel), 32'd2);
    repeat (3) step(8'h0C);
    repeat (2) step(8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
